// File: rtl/shift_sequencer.sv
// -----------------------------------------------------------------------------
// shift_sequencer
//   Multi-cycle SLL/SRL/SRA unit. A narrow shift stage (0..MAX_STEP positions)
//   is applied once per cycle until the requested amount has been consumed.
//   This gives a smaller shifter than a full barrel shifter, at the cost of more
//   latency. Requests and results use valid/ready handshakes.
//
//   Optional feature macro: SHIFT_FLUSH_EN (adds the 'flush' abort input).
//
// Ports
//   clk           in   clock, rising edge
//   rst           in   synchronous reset, active-high
//   in_valid      in   request valid
//   in_ready      out  request accepted when in_valid & in_ready
//   d_in          in   operand
//   shamt         in   shift amount, unsigned
//   arithOrLogic  in   0 = arithmetic (sign fill), 1 = logical; right shifts only
//   leftOrRight   in   1 = shift right, 0 = shift left (zero fill)
//   out_valid     out  result valid
//   out_ready     in   result consumed when out_valid & out_ready
//   d_out         out  result, registered
//   busy          out  1 whenever the FSM is not idle
//   flush         in   (SHIFT_FLUSH_EN only) abort the current op
// -----------------------------------------------------------------------------
module shift_sequencer #(
  parameter int DATA_WIDTH  = 32,
  parameter int SHAMT_WIDTH = 5,
  parameter int STEP_WIDTH  = 2
) (
  input  logic                   clk,
  input  logic                   rst,
`ifdef SHIFT_FLUSH_EN
  input  logic                   flush,
`endif
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [DATA_WIDTH-1:0]  d_in,
  input  logic [SHAMT_WIDTH-1:0] shamt,
  input  logic                   arithOrLogic,
  input  logic                   leftOrRight,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DATA_WIDTH-1:0]  d_out,
  output logic                   busy
);

  localparam int NUM_CAND = 2 ** STEP_WIDTH;
  localparam logic [SHAMT_WIDTH-1:0] MAX_STEP = SHAMT_WIDTH'(NUM_CAND - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t                 r_state;
  logic [DATA_WIDTH-1:0]  r_work;
  logic [SHAMT_WIDTH-1:0] r_remaining;
  logic                   r_right;
  logic                   r_logical;
  logic                   r_out_valid;
  logic [DATA_WIDTH-1:0]  r_d_out;
  logic                   r_busy;

  logic [STEP_WIDTH-1:0]  w_step;
  logic [DATA_WIDTH-1:0]  w_cand [NUM_CAND];
  logic [DATA_WIDTH-1:0]  w_shifted;
  logic                   w_flush;

`ifdef SHIFT_FLUSH_EN
  assign w_flush = flush;
`else
  assign w_flush = 1'b0;
`endif

  // Offered while idle only; reset and flush both block acceptance.
  assign in_ready  = (r_state == S_IDLE) & ~rst & ~w_flush;
  assign out_valid = r_out_valid;
  assign d_out     = r_d_out;
  assign busy      = r_busy;

  // Per-cycle step: min(remaining, MAX_STEP). The less-than test means the
  // low bits of remaining are the whole value in the first branch.
  always_comb begin
    w_step = MAX_STEP[STEP_WIDTH-1:0];
    if (r_remaining < MAX_STEP)
      w_step = r_remaining[STEP_WIDTH-1:0];
  end

  // Narrow shift stage: one candidate per possible step, selected by w_step.
  // The SRA fill comes from the working MSB, which still holds the original
  // sign because arithmetic right shifts preserve it.
  generate
    for (genvar gi = 0; gi < NUM_CAND; gi++) begin : g_cand
      always_comb begin
        if (!r_right)
          w_cand[gi] = r_work << gi;
        else if (r_logical)
          w_cand[gi] = r_work >> gi;
        else
          w_cand[gi] = DATA_WIDTH'($signed(r_work) >>> gi);
      end
    end
  endgenerate

  assign w_shifted = w_cand[w_step];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_work      <= '0;
      r_remaining <= '0;
      r_right     <= 1'b0;
      r_logical   <= 1'b0;
      r_out_valid <= 1'b0;
      r_d_out     <= '0;
      r_busy      <= 1'b0;
    end else if (w_flush) begin
      // Abort: drop the op but keep the last result on d_out.
      r_state     <= S_IDLE;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_work      <= d_in;
            r_remaining <= shamt;
            r_right     <= leftOrRight;
            r_logical   <= arithOrLogic;
            r_busy      <= 1'b1;
            if (shamt == '0) begin
              // Nothing to shift: result is the operand itself.
              r_d_out     <= d_in;
              r_out_valid <= 1'b1;
              r_state     <= S_DONE;
            end else begin
              r_state <= S_SHIFT;
            end
          end
        end
        S_SHIFT: begin
          r_work      <= w_shifted;
          r_remaining <= r_remaining - SHAMT_WIDTH'(w_step);
          if (r_remaining == SHAMT_WIDTH'(w_step)) begin
            r_d_out     <= w_shifted;
            r_out_valid <= 1'b1;
            r_state     <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_out_valid <= 1'b0;
          r_busy      <= 1'b0;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

endmodule
